// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - measurement result bus published by pwm_capture
interface pwm_capture_if #(
    parameter int W = 5
);
    logic [W-1:0] highCount_o;
    logic [W-1:0] periodCount_o;
    logic         dataValid_STRB_o;
    logic         timeout_o;

    modport master (
        output highCount_o,
        output periodCount_o,
        output dataValid_STRB_o,
        output timeout_o
    );

    modport slave (
        input highCount_o,
        input periodCount_o,
        input dataValid_STRB_o,
        input timeout_o
    );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time/period decoder; PWM_CAPTURE_FILTER_EN adds a 2-sample deglitch
module pwm_capture #(
    parameter int COUNTER_BITWIDTH = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          clk_en_i,
    input  logic          enable_i,
    input  logic          pwm_pin_i,
    pwm_capture_if.master res
);
    localparam int W = COUNTER_BITWIDTH + 1;
    localparam logic [W-1:0] MAXCNT = '1;

    typedef enum logic [1:0] {IDLE, SYNC, MEAS} state_t;

    logic         sync1_q, sync2_q;
    logic         samp_q, samp_prev_q, samp_d;
    logic         rise;
    state_t       state_q;
    logic [W-1:0] period_q, high_q;
    logic [W-1:0] high_out_q, period_out_q;
    logic         strb_q, timeout_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_pin_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic filt_q;

    // s follows the synchronizer only once two consecutive ticks agree
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filt_q <= 1'b0;
        end else if (clk_en_i) begin
            filt_q <= sync2_q;
        end
    end

    assign samp_d = (sync2_q == filt_q) ? sync2_q : samp_q;
`else
    assign samp_d = sync2_q;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            samp_q      <= 1'b0;
            samp_prev_q <= 1'b0;
        end else if (clk_en_i) begin
            samp_q      <= samp_d;
            samp_prev_q <= samp_q;
        end
    end

    assign rise = clk_en_i & samp_q & ~samp_prev_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            period_q     <= '0;
            high_q       <= '0;
            high_out_q   <= '0;
            period_out_q <= '0;
            strb_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else if (!enable_i) begin
            // disable beats any completion on the same cycle; results hold
            state_q   <= IDLE;
            period_q  <= '0;
            high_q    <= '0;
            strb_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            strb_q <= 1'b0;
            if (clk_en_i) begin
                case (state_q)
                    IDLE: state_q <= SYNC;
                    SYNC: begin
                        if (rise) begin
                            period_q <= W'(1);
                            high_q   <= W'(1);
                            state_q  <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (rise) begin
                            high_out_q   <= high_q;
                            period_out_q <= period_q;
                            strb_q       <= 1'b1;
                            timeout_q    <= 1'b0;
                            period_q     <= W'(1);
                            high_q       <= W'(1);
                        end else if (period_q == MAXCNT) begin
                            high_out_q   <= samp_q ? MAXCNT : '0;
                            period_out_q <= MAXCNT;
                            strb_q       <= 1'b1;
                            timeout_q    <= 1'b1;
                            period_q     <= '0;
                            high_q       <= '0;
                            state_q      <= SYNC;
                        end else begin
                            period_q <= period_q + W'(1);
                            if (samp_q) begin
                                high_q <= high_q + W'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign res.highCount_o      = high_out_q;
    assign res.periodCount_o    = period_out_q;
    assign res.dataValid_STRB_o = strb_q;
    assign res.timeout_o        = timeout_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;
    localparam int CB = 4;
    localparam int W  = CB + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clk_en = 1'b1;
    logic enable = 1'b0;
    logic pin = 1'b0;

    pwm_capture_if #(.W(W)) res ();

    pwm_capture #(.COUNTER_BITWIDTH(CB)) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .clk_en_i  (clk_en),
        .enable_i  (enable),
        .pwm_pin_i (pin),
        .res       (res)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int en_div = 1;
    int div_cnt = 0;
    int q_h[$];
    int q_p[$];
    int q_t[$];
    int wide = 0;
    logic prev_strb = 1'b0;

    always @(posedge clk) begin
        #1;
        div_cnt = (div_cnt + 1) % en_div;
        clk_en  = (div_cnt == 0);
    end

    always @(negedge clk) begin
        if (res.dataValid_STRB_o === 1'b1) begin
            q_h.push_back(int'(res.highCount_o));
            q_p.push_back(int'(res.periodCount_o));
            q_t.push_back(int'(res.timeout_o));
        end
        if (res.dataValid_STRB_o === 1'b1 && prev_strb === 1'b1) wide++;
        prev_strb = res.dataValid_STRB_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pwm(input int h, input int l);
        pin = 1'b1;
        tick(h);
        pin = 1'b0;
        tick(l);
    endtask

    task automatic clear_q();
        q_h.delete();
        q_p.delete();
        q_t.delete();
    endtask

    task automatic restart();
        enable = 1'b0;
        pin = 1'b0;
        tick(3);
        clear_q();
        wide = 0;
        enable = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        enable = 1'b0;
        pin = 1'b0;
        tick(3);
        total++; if (res.highCount_o !== '0) begin bad++; $display("FAIL reset_high got=%0d exp=0", res.highCount_o); end
        total++; if (res.periodCount_o !== '0) begin bad++; $display("FAIL reset_period got=%0d exp=0", res.periodCount_o); end
        total++; if (res.dataValid_STRB_o !== 1'b0) begin bad++; $display("FAIL reset_strb got=%0b exp=0", res.dataValid_STRB_o); end
        total++; if (res.timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b exp=0", res.timeout_o); end
        rstn = 1'b1;
        tick(2);
    endtask

    task automatic test_steady();
        en_div = 1;
        restart();
        repeat (4) pwm(6, 10);
        pin = 1'b1;
        tick(8);
        total++; if (q_h.size() !== 4) begin bad++; $display("FAIL steady_count got=%0d exp=4", q_h.size()); end
        for (int i = 0; i < q_h.size(); i++) begin
            total++;
            if (q_h[i] !== 6 || q_p[i] !== 16 || q_t[i] !== 0) begin
                bad++; $display("FAIL steady_val[%0d] got=%0d/%0d/%0d exp=6/16/0", i, q_h[i], q_p[i], q_t[i]);
            end
        end
        total++; if (wide !== 0) begin bad++; $display("FAIL steady_width got=%0d exp=0", wide); end
    endtask

    task automatic test_slow_tick();
        en_div = 4;
        restart();
        repeat (3) pwm(24, 40);
        pin = 1'b1;
        tick(16);
        total++; if (q_h.size() !== 3) begin bad++; $display("FAIL slow_count got=%0d exp=3", q_h.size()); end
        for (int i = 0; i < q_h.size(); i++) begin
            total++;
            if (q_h[i] !== 6 || q_p[i] !== 16 || q_t[i] !== 0) begin
                bad++; $display("FAIL slow_val[%0d] got=%0d/%0d/%0d exp=6/16/0", i, q_h[i], q_p[i], q_t[i]);
            end
        end
        total++; if (wide !== 0) begin bad++; $display("FAIL slow_width got=%0d exp=0", wide); end
        en_div = 1;
    endtask

    task automatic test_timeout();
        int eh[4] = '{6, 31, 0, 6};
        int ep[4] = '{16, 31, 31, 16};
        int et[4] = '{0, 1, 1, 0};
        restart();
        pwm(6, 10);
        pin = 1'b1;
        tick(40);
        total++; if (res.timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_high_flag got=%0b exp=1", res.timeout_o); end
        pin = 1'b0;
        tick(10);
        pwm(6, 40);
        total++; if (res.timeout_o !== 1'b1) begin bad++; $display("FAIL timeout_low_flag got=%0b exp=1", res.timeout_o); end
        pwm(6, 10);
        pin = 1'b1;
        tick(8);
        total++; if (q_h.size() !== 4) begin bad++; $display("FAIL timeout_count got=%0d exp=4", q_h.size()); end
        for (int i = 0; i < 4 && i < q_h.size(); i++) begin
            total++;
            if (q_h[i] !== eh[i] || q_p[i] !== ep[i] || q_t[i] !== et[i]) begin
                bad++; $display("FAIL timeout_val[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, q_h[i], q_p[i], q_t[i], eh[i], ep[i], et[i]);
            end
        end
        total++; if (res.timeout_o !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%0b exp=0", res.timeout_o); end
    endtask

    task automatic test_glitch();
`ifdef PWM_CAPTURE_FILTER_EN
        int n = 2;
        int eh[3] = '{6, 6, 0};
        int ep[3] = '{16, 16, 0};
`else
        int n = 3;
        int eh[3] = '{6, 3, 2};
        int ep[3] = '{16, 4, 12};
`endif
        restart();
        pwm(6, 10);
        pin = 1'b1;
        tick(3);
        pin = 1'b0;
        tick(1);
        pwm(2, 10);
        pin = 1'b1;
        tick(8);
        total++; if (q_h.size() !== n) begin bad++; $display("FAIL glitch_count got=%0d exp=%0d", q_h.size(), n); end
        for (int i = 0; i < n && i < q_h.size(); i++) begin
            total++;
            if (q_h[i] !== eh[i] || q_p[i] !== ep[i] || q_t[i] !== 0) begin
                bad++; $display("FAIL glitch_val[%0d] got=%0d/%0d/%0d exp=%0d/%0d/0", i, q_h[i], q_p[i], q_t[i], eh[i], ep[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        restart();
        pwm(6, 10);
        pwm(6, 10);
        pin = 1'b1;
        tick(6);
        pin = 1'b0;
        tick(5);
        rstn = 1'b0;
        #1;
        total++; if (res.highCount_o !== '0) begin bad++; $display("FAIL rstmid_high got=%0d exp=0", res.highCount_o); end
        total++; if (res.periodCount_o !== '0) begin bad++; $display("FAIL rstmid_period got=%0d exp=0", res.periodCount_o); end
        total++; if (res.dataValid_STRB_o !== 1'b0) begin bad++; $display("FAIL rstmid_strb got=%0b exp=0", res.dataValid_STRB_o); end
        total++; if (res.timeout_o !== 1'b0) begin bad++; $display("FAIL rstmid_timeout got=%0b exp=0", res.timeout_o); end
        tick(2);
        rstn = 1'b1;
        clear_q();
        tick(4);
        pwm(6, 10);
        total++; if (q_h.size() !== 0) begin bad++; $display("FAIL rstmid_early got=%0d exp=0", q_h.size()); end
        pin = 1'b1;
        tick(8);
        total++; if (q_h.size() !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", q_h.size()); end
        if (q_h.size() > 0) begin
            total++;
            if (q_h[0] !== 6 || q_p[0] !== 16 || q_t[0] !== 0) begin
                bad++; $display("FAIL rstmid_val got=%0d/%0d/%0d exp=6/16/0", q_h[0], q_p[0], q_t[0]);
            end
        end
    endtask

    task automatic test_enable_drop();
`ifdef PWM_CAPTURE_FILTER_EN
        int lat = 4;
`else
        int lat = 3;
`endif
        restart();
        pwm(6, 10);
        pwm(6, 10);
        pin = 1'b1;
        tick(lat);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(4);
        total++; if (q_h.size() !== 1) begin bad++; $display("FAIL endrop_count got=%0d exp=1", q_h.size()); end
        total++; if (res.highCount_o !== 5'd6) begin bad++; $display("FAIL endrop_high got=%0d exp=6", res.highCount_o); end
        total++; if (res.periodCount_o !== 5'd16) begin bad++; $display("FAIL endrop_period got=%0d exp=16", res.periodCount_o); end
        total++; if (res.timeout_o !== 1'b0) begin bad++; $display("FAIL endrop_timeout got=%0b exp=0", res.timeout_o); end
        tick(1);
        pin = 1'b0;
        tick(10);
        pwm(6, 10);
        total++; if (q_h.size() !== 1) begin bad++; $display("FAIL endrop_resync got=%0d exp=1", q_h.size()); end
        pin = 1'b1;
        tick(8);
        total++; if (q_h.size() !== 2) begin bad++; $display("FAIL endrop_after got=%0d exp=2", q_h.size()); end
        if (q_h.size() > 1) begin
            total++;
            if (q_h[1] !== 6 || q_p[1] !== 16 || q_t[1] !== 0) begin
                bad++; $display("FAIL endrop_val got=%0d/%0d/%0d exp=6/16/0", q_h[1], q_p[1], q_t[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_slow_tick();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
